if_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipelined MIPS core. It owns the program counter and drives the word address of the combinational instruction ROM. It registers the returned word into the IF/ID pipeline register and applies stall, redirect (branch/jump) and flush. It also stops fetching cleanly when the PC leaves the populated ROM range.

---
 rtl/if_fetch_ctrl_pkg.sv | 14 +
 rtl/if_fetch_ctrl_if.sv | 31 +++
 rtl/if_fetch_ctrl_if_id_reg.sv | 39 +++
 rtl/if_fetch_ctrl.sv | 98 +++++++++
 tb/tb_if_fetch_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// PC increment and the bubble instruction word.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam int          PC_STEP  = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bus: hazard/redirect inputs, ROM port and IF/ID outputs.
interface if_fetch_ctrl_if #(
  parameter int DWL = 32,
  parameter int AWL = 32
);

  logic           stall_i;
  logic           redirect_i;
  logic [AWL-1:0] redirect_pc_i;
  logic [AWL-1:0] rom_addr_o;
  logic [DWL-1:0] rom_data_i;
  logic [DWL-1:0] ifid_instr_o;
  logic [AWL-1:0] ifid_pc4_o;
  logic           ifid_valid_o;
  logic [AWL-1:0] pc_o;
  logic           halted_o;
  logic [31:0]    fetch_cnt_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, rom_data_i,
    output rom_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o,
           pc_o, halted_o, fetch_cnt_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, rom_data_i,
    input  rom_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o,
           pc_o, halted_o, fetch_cnt_o
  );

endinterface

// File: rtl/if_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: clear beats hold, hold beats capture,
// and an idle cycle leaves a bubble behind the last instruction.
module if_id_reg
  import if_fetch_ctrl_pkg::*;
#(
  parameter int DWL = 32,
  parameter int AWL = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           hold,
  input  logic           capture,
  input  logic [DWL-1:0] instr_d,
  input  logic [AWL-1:0] pc4_d,
  output logic [DWL-1:0] instr_q,
  output logic [AWL-1:0] pc4_q,
  output logic           valid_q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      instr_q <= DWL'(NOP_WORD);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (hold) begin
      instr_q <= instr_q;
      pc4_q   <= pc4_q;
      valid_q <= valid_q;
    end else if (capture) begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, next-PC selection and the
// BOOT/RUN/HALT controller feeding the IF/ID register.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int             DWL      = 32,
  parameter int             AWL      = 32,
  parameter int             DEPTH    = 32,
  parameter logic [AWL-1:0] RESET_PC = '0
) (
  input  logic CLK,
  input  logic RST_N,
  if_fetch_ctrl_if.master bus
);

  localparam logic [AWL-1:0] RESET_IDX = RESET_PC >> 2;
  localparam logic [AWL-1:0] DEPTH_W   = AWL'(DEPTH);
  localparam logic [AWL-1:0] STEP_W    = AWL'(PC_STEP);

  fetch_state_t   state;
  logic [AWL-1:0] pc;
  logic [AWL-1:0] word_idx;
  logic [AWL-1:0] pc_next;
  logic [31:0]    fetch_cnt;
  logic           out_of_range;
  logic           run_fetch;

  assign word_idx     = {2'b00, pc[AWL-1:2]};
  assign out_of_range = (word_idx >= DEPTH_W);
  assign pc_next      = pc + STEP_W;
  assign run_fetch    = (state == ST_RUN) && !bus.redirect_i && !bus.stall_i
                        && !out_of_range;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      fetch_cnt <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (bus.redirect_i) begin
            pc    <= bus.redirect_pc_i;
            state <= ST_RUN;
          end else begin
            state <= (RESET_IDX >= DEPTH_W) ? ST_HALT : ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.redirect_i) begin
            pc <= bus.redirect_pc_i;
          end else if (bus.stall_i) begin
            pc <= pc;
          end else if (out_of_range) begin
            state <= ST_HALT;
          end else begin
            pc        <= pc_next;
            fetch_cnt <= fetch_cnt + 32'd1;
          end
        end
        ST_HALT: begin
          if (bus.redirect_i) begin
            pc    <= bus.redirect_pc_i;
            state <= ST_RUN;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  // Hold only applies while running; a redirect always flushes wrong-path work.
  logic [DWL-1:0] ifid_instr;
  logic [AWL-1:0] ifid_pc4;
  logic           ifid_valid;

  if_id_reg #(.DWL(DWL), .AWL(AWL)) u_if_id_reg (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear   (bus.redirect_i),
    .hold    ((state == ST_RUN) && bus.stall_i),
    .capture (run_fetch),
    .instr_d (bus.rom_data_i),
    .pc4_d   (pc_next),
    .instr_q (ifid_instr),
    .pc4_q   (ifid_pc4),
    .valid_q (ifid_valid)
  );

  assign bus.rom_addr_o   = word_idx;
  assign bus.ifid_instr_o = ifid_instr;
  assign bus.ifid_pc4_o   = ifid_pc4;
  assign bus.ifid_valid_o = ifid_valid;
  assign bus.pc_o         = pc;
  assign bus.halted_o     = (state == ST_HALT);
  assign bus.fetch_cnt_o  = fetch_cnt;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a 32-word combinational ROM model.
module tb_if_fetch_ctrl;

  logic CLK;
  logic RST_N;
  int   compared;
  int   mismatched;

  if_fetch_ctrl_if #(.DWL(32), .AWL(32)) bus ();

  if_fetch_ctrl #(.DWL(32), .AWL(32), .DEPTH(32), .RESET_PC(32'h0)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ROM word i holds 0x2400_0000 | i; anything beyond holds all-ones.
  always_comb begin
    bus.rom_data_i = 32'hFFFF_FFFF;
    if (bus.rom_addr_o < 32'd32) bus.rom_data_i = 32'h2400_0000 | bus.rom_addr_o;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] p4);
    chk({tag, ".valid"}, {31'd0, bus.ifid_valid_o}, {31'd0, v});
    chk({tag, ".instr"}, bus.ifid_instr_o, ins);
    chk({tag, ".pc4"},   bus.ifid_pc4_o,   p4);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    RST_N = 1'b0;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    step();
    step();
    chk_if("rst", 1'b0, 32'h0, 32'h0);
    chk("rst.pc",  bus.pc_o, 32'h0);
    chk("rst.cnt", bus.fetch_cnt_o, 32'd0);
    chk("rst.halt", {31'd0, bus.halted_o}, 32'd0);

    RST_N = 1'b1;
    step();
    chk("boot.valid", {31'd0, bus.ifid_valid_o}, 32'd0);
    chk("boot.pc", bus.pc_o, 32'h0);
    step();
    chk_if("e2", 1'b1, 32'h2400_0000, 32'h4);
    step();
    chk_if("e3", 1'b1, 32'h2400_0001, 32'h8);

    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_if("stall", 1'b1, 32'h2400_0001, 32'h8);
    chk("stall.pc",  bus.pc_o, 32'h8);
    chk("stall.cnt", bus.fetch_cnt_o, 32'd2);
    bus.stall_i = 1'b0;
    step();
    chk_if("e4", 1'b1, 32'h2400_0002, 32'hC);
    chk("e4.cnt", bus.fetch_cnt_o, 32'd3);

    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h14;
    step();
    chk_if("rdst", 1'b0, 32'h0, 32'h0);
    chk("rdst.pc", bus.pc_o, 32'h14);
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    step();
    chk_if("tgt5", 1'b1, 32'h2400_0005, 32'h18);
    chk("tgt5.cnt", bus.fetch_cnt_o, 32'd4);

    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0A;
    step();
    bus.redirect_i = 1'b0;
    chk("mis.pc", bus.pc_o, 32'h0A);
    chk("mis.addr", bus.rom_addr_o, 32'd2);
    step();
    chk_if("mis", 1'b1, 32'h2400_0002, 32'h0E);

    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h70;
    step();
    bus.redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_if("w31", 1'b1, 32'h2400_001F, 32'h80);
    chk("w31.pc", bus.pc_o, 32'h80);
    step();
    chk("halt.h", {31'd0, bus.halted_o}, 32'd1);
    chk("halt.valid", {31'd0, bus.ifid_valid_o}, 32'd0);
    chk("halt.pc", bus.pc_o, 32'h80);
    chk("halt.cnt", bus.fetch_cnt_o, 32'd9);
    bus.stall_i = 1'b1;
    step();
    bus.stall_i = 1'b0;
    chk("halt2.h", {31'd0, bus.halted_o}, 32'd1);
    chk("halt2.pc", bus.pc_o, 32'h80);

    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0;
    step();
    bus.redirect_i = 1'b0;
    chk("unh.h", {31'd0, bus.halted_o}, 32'd0);
    chk("unh.valid", {31'd0, bus.ifid_valid_o}, 32'd0);
    step();
    chk_if("unh", 1'b1, 32'h2400_0000, 32'h4);
    chk("unh.cnt", bus.fetch_cnt_o, 32'd10);

    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h100;
    step();
    bus.redirect_i = 1'b0;
    chk("oob.h", {31'd0, bus.halted_o}, 32'd0);
    chk("oob.pc", bus.pc_o, 32'h100);
    step();
    chk("oob2.h", {31'd0, bus.halted_o}, 32'd1);
    chk("oob2.valid", {31'd0, bus.ifid_valid_o}, 32'd0);
    chk("oob2.cnt", bus.fetch_cnt_o, 32'd10);

    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0;
    step();
    bus.redirect_i = 1'b0;
    step();
    chk("pre.cnt", bus.fetch_cnt_o, 32'd11);
    RST_N = 1'b0;
    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h40;
    step();
    chk_if("mrst", 1'b0, 32'h0, 32'h0);
    chk("mrst.pc", bus.pc_o, 32'h0);
    chk("mrst.cnt", bus.fetch_cnt_o, 32'd0);
    chk("mrst.h", {31'd0, bus.halted_o}, 32'd0);
    RST_N = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    step();
    chk("mboot.valid", {31'd0, bus.ifid_valid_o}, 32'd0);
    step();
    chk_if("mrun", 1'b1, 32'h2400_0000, 32'h4);
    chk("mrun.cnt", bus.fetch_cnt_o, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
